// File: rtl/square_iter.sv
// Iterative shift-and-add squarer: one root bit per cycle, MSB first, val/rdy in and out.
// Optional SQUARE_ADDEND_EN adds recv_add to the square on completion (radicand rebuild).
module square_iter #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BIT_WIDTH/2-1:0] recv_msg,
`ifdef SQUARE_ADDEND_EN
  input  logic [BIT_WIDTH/2:0]   recv_add,
`endif
  input  logic                   recv_val,
  output logic                   recv_rdy,
  output logic [BIT_WIDTH-1:0]   send_msg,
  output logic                   send_val,
  input  logic                   send_rdy
);

  localparam int ITER  = BIT_WIDTH / 2;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [ITER-1:0]      q_r;
  logic [ITER-1:0]      qs_r;
  logic [CNT_W-1:0]     i_r;
  logic [BIT_WIDTH-1:0] acc_r;
  logic [BIT_WIDTH-1:0] result_r;
  logic [ITER:0]        addend;
  logic                 calc_fin;

`ifdef SQUARE_ADDEND_EN
  logic [ITER:0]        add_r;
  assign addend = add_r;
`else
  assign addend = '0;
`endif

  // One shift-and-add step; the zero-extended root is added when the current root bit is set.
  function automatic logic [BIT_WIDTH-1:0] sq_step(input logic [BIT_WIDTH-1:0] acc,
                                                    input logic [ITER-1:0]      q,
                                                    input logic                 bit_v);
    logic [BIT_WIDTH-1:0] pp;
    pp = bit_v ? BIT_WIDTH'(q) : '0;
    return (acc << 1) + pp;
  endfunction

  // Final addition wraps modulo 2^BIT_WIDTH.
  function automatic logic [BIT_WIDTH-1:0] add_wrap(input logic [BIT_WIDTH-1:0] acc,
                                                     input logic [ITER:0]        add);
    return acc + BIT_WIDTH'(add);
  endfunction

  // After ITER steps one finalize cycle moves acc (+ addend) into the result register.
  assign calc_fin = (i_r == CNT_W'(ITER));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    case (state)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) state_nx = CALC;
      end
      CALC: begin
        if (calc_fin) state_nx = DONE;
      end
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // qs_r is a left-shifting copy of q so its MSB is always the root bit for the current step.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r      <= '0;
      qs_r     <= '0;
      i_r      <= '0;
      acc_r    <= '0;
      result_r <= '0;
`ifdef SQUARE_ADDEND_EN
      add_r    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (recv_val) begin
            q_r   <= recv_msg;
            qs_r  <= recv_msg;
            i_r   <= '0;
            acc_r <= '0;
`ifdef SQUARE_ADDEND_EN
            add_r <= recv_add;
`endif
          end
        end
        CALC: begin
          if (calc_fin) begin
            result_r <= add_wrap(acc_r, addend);
          end else begin
            acc_r <= sq_step(acc_r, q_r, qs_r[ITER-1]);
            qs_r  <= qs_r << 1;
            i_r   <= i_r + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign send_msg = result_r;

endmodule

// File: tb/tb_square_iter.sv
// Self-checking bench for square_iter: table vectors, hand-written corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_square_iter;
  localparam int BW = 8;
  localparam int H  = BW / 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [H-1:0]  recv_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [BW-1:0] send_msg;
  logic          send_val;
  logic          send_rdy;
`ifdef SQUARE_ADDEND_EN
  logic [H:0]    recv_add;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    int q;
    int a;
    int stall;
    int exp;
  } vec_t;

  square_iter #(.BIT_WIDTH(BW)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
`ifdef SQUARE_ADDEND_EN
    .recv_add (recv_add),
`endif
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int model(input int q, input int a);
    return (q * q + a) % (1 << BW);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int q, input int a, input int stall, input int alt,
                        input int exp, input string name);
    int n;
    n = 0;
    while (!recv_rdy && n < 50) begin
      tick();
      n++;
    end
    chk({name, " ready"}, recv_rdy, 1);
    recv_msg = q[H-1:0];
`ifdef SQUARE_ADDEND_EN
    recv_add = a[H:0];
`endif
    recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    recv_msg = alt[H-1:0];
    n = 0;
    while (!send_val && n < 20) begin
      tick();
      n++;
    end
    chk({name, " latency"}, n, H + 1);
    chk({name, " result"}, send_msg, exp);
    chk({name, " rdy low in done"}, recv_rdy, 0);
    for (int k = 0; k < stall; k++) begin
      tick();
      chk({name, " hold msg"}, send_msg, exp);
      chk({name, " hold val"}, send_val, 1);
      chk({name, " hold rdy"}, recv_rdy, 0);
    end
    send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
    chk({name, " idle rdy"}, recv_rdy, 1);
    chk({name, " idle val"}, send_val, 0);
  endtask

  initial begin
    vec_t tbl[$];
    int   seen;
    int   q, a, st;

    reset    = 1'b1;
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b0;
`ifdef SQUARE_ADDEND_EN
    recv_add = '0;
`endif
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset rdy", recv_rdy, 1);
    chk("reset val", send_val, 0);
    chk("reset msg", send_msg, 0);

    tbl.push_back('{q: 0,  a: 0,  stall: 0, exp: 0});
    tbl.push_back('{q: 1,  a: 0,  stall: 1, exp: 1});
    tbl.push_back('{q: 11, a: 0,  stall: 6, exp: 121});
    tbl.push_back('{q: 15, a: 0,  stall: 2, exp: 225});
`ifdef SQUARE_ADDEND_EN
    tbl.push_back('{q: 11, a: 7,  stall: 0, exp: 128});
    tbl.push_back('{q: 15, a: 30, stall: 1, exp: 255});
`endif
    foreach (tbl[i])
      run_op(tbl[i].q, tbl[i].a, tbl[i].stall, tbl[i].q, tbl[i].exp, $sformatf("vec%0d", i));

    // recv_msg changes to 3 during CALC; result must still be 11*11
    run_op(11, 0, 0, 3, 121, "msg change");

    // reset two cycles into CALC abandons the operation
    recv_msg = 4'd9;
    recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort rdy", recv_rdy, 1);
    chk("abort val", send_val, 0);
    chk("abort msg", send_msg, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (send_val) seen = 1;
    end
    chk("abort no send", seen, 0);
    run_op(9, 0, 0, 9, 81, "after abort");

    for (int r = 0; r < 25; r++) begin
      q  = int'($urandom_range(0, (1 << H) - 1));
`ifdef SQUARE_ADDEND_EN
      a  = int'($urandom_range(0, (1 << (H + 1)) - 1));
`else
      a  = 0;
`endif
      st = int'($urandom_range(0, 3));
      run_op(q, a, st, int'($urandom), model(q, a), $sformatf("rand%0d q=%0d a=%0d", r, q, a));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
